lsq_dc_arb: RTL and testbench
=============================

Name: lsq_dc_arb

Overview:
- Arbitrates the single dcache request port between the load-issue path and the retired-store drain path of the load-store queue.
- Holds the winning request in a one-entry registered output stage toward the dcache.
- Policy: loads first by default, with a starvation guard and a hysteresis drain mode that gives stores priority when retired stores back up.
- Handles pipeline flush: speculative loads are dropped, retired stores are never lost.

Parameters:
STARVE_MAX, 8, consecutive lost arbitration cycles after which a waiting store is forced to win (1..15)
HIWAT, 12, st_pending level at which DRAIN mode is entered
LOWAT, 4, st_pending level at or below which DRAIN mode exits (LOWAT < HIWAT)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ld_req  in  1  load request valid
ld_op  in  4  load op {type,1'b0}
ld_addr  in  32  load address
ld_lsqid  in  4  load queue index
ld_wdata  in  32  load auxiliary data (lbcmp operand)
ld_grant  out  1  load accepted this cycle (comb)
st_req  in  1  store-at-head request valid
st_op  in  4  store op {type,1'b1}
st_addr  in  32  store address
st_wdata  in  32  store data
st_pending  in  5  retired-but-unissued store count (0..16)
st_grant  out  1  store accepted this cycle (comb)
flush  in  1  pipeline flush
dc_req  out  1  request valid to dcache (registered)
dc_op  out  4  registered op
dc_addr  out  32  registered address
dc_lsqid  out  4  registered lsqid (0 for stores)
dc_wdata  out  32  registered data
dc_flush  out  1  equals flush, combinational passthrough
dc_ready  in  1  dcache accepts dc_req this cycle
mode_drain  out  1  DRAIN state indicator (registered)

Behaviour:
- Reset: dc_req=0, dc_op/addr/lsqid/wdata=0, mode_drain=0, starvation counter=0, FSM=NORMAL; grants are 0 while rst is high.
- Slot free when ~dc_req | dc_ready. Grants are issued only if the slot is free and flush=0. At most one grant per cycle.
- Winner selection:
  - store wins if st_req & (FSM==DRAIN | starve==STARVE_MAX | ~ld_req);
  - otherwise the load wins if ld_req.
- On grant, the winner's fields load the output register next cycle and dc_req=1. Latency is 1 cycle from grant to dc_req.
- Stores drive dc_lsqid=0.
- If the slot is drained (dc_ready) and nothing is granted, dc_req goes to 0.
- Output fields are held stable while dc_req & ~dc_ready.
- Starvation counter (4 bits):
  - +1 (saturating at STARVE_MAX) in each cycle that st_req=1, the slot is free, flush=0, and the store loses;
  - cleared on st_grant;
  - holds otherwise.
- FSM:
  - NORMAL->DRAIN when st_pending >= HIWAT;
  - DRAIN->NORMAL when st_pending <= LOWAT;
  - evaluated every cycle including flush cycles; mode_drain reflects state.
- Flush:
  - no grants in the flush cycle;
  - if the output register holds a load (dc_op[0]=0), dc_req clears next cycle regardless of dc_ready;
  - a held store stays valid until accepted;
  - dc_flush=flush.
- Flush and dc_ready in the same cycle with a held load: the dcache sees both; the register still clears.
- Simultaneous ld_req & st_req with the counter below STARVE_MAX in NORMAL: load wins and the counter increments.
- st_pending values above 16 are not legal; behaviour is as compared numerically.

Test Plan:
- Reset then ld_req=1, lsqid=5, addr=0x1000, dc_ready=1 -> ld_grant=1 in cycle 0; dc_req=1, dc_lsqid=5, dc_addr=0x1000 in cycle 1.
- Backpressure: grant a load with dc_ready=0 for 3 cycles while ld_req and st_req stay high -> no grants, dc_* stable 3 cycles; grant resumes the cycle dc_ready=1.
- Starvation: ld_req and st_req high continuously, dc_ready=1, STARVE_MAX=8, st_pending=2 -> 8 load grants, then st_grant on the 9th cycle; counter back to 0, loads resume.
- Drain hysteresis: st_pending stepped 11->12 -> mode_drain=1 next cycle and stores win against loads; step down to 5 -> still DRAIN; step to 4 -> NORMAL next cycle.
- Flush with held load: load in register, dc_ready=0, flush=1 -> no grants that cycle, dc_req=0 next cycle, dc_flush=1 in the flush cycle.
- Flush with held store: repeat with a held store -> dc_req stays 1 with the same addr/data until dc_ready.

Source files
------------

// File: rtl/lsq_dc_arb.sv
// -----------------------------------------------------------------------------
// lsq_dc_arb
//   Arbitrates the single dcache request port between the load-issue path and
//   the retired-store drain path of the load-store queue. The winner is held in
//   a one-entry registered output stage toward the dcache.
//
//   Policy: loads win by default. A waiting store is forced through after
//   STARVE_MAX consecutive lost arbitrations. A hysteresis DRAIN mode, entered
//   at st_pending >= HIWAT and left at st_pending <= LOWAT, gives stores
//   priority. On flush, a held load is dropped but a held store is kept until
//   the dcache accepts it.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ld_req/op/addr/lsqid/wdata   load-issue request
//   ld_grant                     load accepted this cycle (combinational)
//   st_req/op/addr/wdata         store-at-head request
//   st_pending                   retired-but-unissued store count (0..16)
//   st_grant                     store accepted this cycle (combinational)
//   flush                        pipeline flush
//   dc_req/op/addr/lsqid/wdata   registered request to the dcache
//   dc_flush                     combinational copy of flush
//   dc_ready                     dcache accepts dc_req this cycle
//   mode_drain                   DRAIN state indicator (registered)
// -----------------------------------------------------------------------------
module lsq_dc_arb #(
    parameter int STARVE_MAX = 8,
    parameter int HIWAT      = 12,
    parameter int LOWAT      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_req,
    input  logic [3:0]  ld_op,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_lsqid,
    input  logic [31:0] ld_wdata,
    output logic        ld_grant,
    input  logic        st_req,
    input  logic [3:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [4:0]  st_pending,
    output logic        st_grant,
    input  logic        flush,
    output logic        dc_req,
    output logic [3:0]  dc_op,
    output logic [31:0] dc_addr,
    output logic [3:0]  dc_lsqid,
    output logic [31:0] dc_wdata,
    output logic        dc_flush,
    input  logic        dc_ready,
    output logic        mode_drain
);

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [4:0] HI_LEVEL   = 5'(HIWAT);
    localparam logic [4:0] LO_LEVEL   = 5'(LOWAT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve;
    logic       slot_free;
    logic       can_grant;
    logic       st_win;

    assign dc_flush   = flush;
    assign mode_drain = (state == DRAIN);

    // Arbitration. The output stage is free when empty or being drained.
    always_comb begin
        // NOTE: every signal driven here is assigned on every path; a missing
        // assignment on some path would infer a latch.
        slot_free = ~dc_req | dc_ready;
        can_grant = slot_free & ~flush & ~rst;
        st_win    = st_req & ((state == DRAIN) | (starve == STARVE_LIM) | ~ld_req);
        st_grant  = can_grant & st_win;
        ld_grant  = can_grant & ~st_win & ld_req;
    end

    // Mode FSM: next-state logic. Evaluated every cycle, flush included.
    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL:  if (st_pending >= HI_LEVEL) state_nxt = DRAIN;
            DRAIN:   if (st_pending <= LO_LEVEL) state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= NORMAL;
        else     state <= state_nxt;
    end

    // Starvation counter: counts arbitration cycles a ready store lost to a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= '0;
        end else if (st_grant) begin
            starve <= '0;
        end else if (st_req & slot_free & ~flush) begin
            if (starve != STARVE_LIM) starve <= starve + 4'd1;
        end
    end

    // One-entry output stage. Fields only change on a grant, so they stay
    // stable while the dcache backpressures.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_req   <= 1'b0;
            dc_op    <= '0;
            dc_addr  <= '0;
            dc_lsqid <= '0;
            dc_wdata <= '0;
        end else if (st_grant) begin
            dc_req   <= 1'b1;
            dc_op    <= st_op;
            dc_addr  <= st_addr;
            dc_lsqid <= '0;
            dc_wdata <= st_wdata;
        end else if (ld_grant) begin
            dc_req   <= 1'b1;
            dc_op    <= ld_op;
            dc_addr  <= ld_addr;
            dc_lsqid <= ld_lsqid;
            dc_wdata <= ld_wdata;
        end else if (dc_ready | (flush & ~dc_op[0])) begin
            // Accepted, or a speculative load squashed by flush. A held store
            // (dc_op[0]=1) survives the flush and waits for dc_ready.
            dc_req   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsq_dc_arb.sv
// -----------------------------------------------------------------------------
// tb_lsq_dc_arb
//   Self-checking bench for lsq_dc_arb: directed scenarios followed by random
//   traffic, all checked cycle by cycle against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_lsq_dc_arb;

    localparam int STARVE_MAX = 8;
    localparam int HIWAT      = 12;
    localparam int LOWAT      = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req;
    logic [3:0]  ld_op;
    logic [31:0] ld_addr;
    logic [3:0]  ld_lsqid;
    logic [31:0] ld_wdata;
    logic        ld_grant;
    logic        st_req;
    logic [3:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [4:0]  st_pending;
    logic        st_grant;
    logic        flush;
    logic        dc_req;
    logic [3:0]  dc_op;
    logic [31:0] dc_addr;
    logic [3:0]  dc_lsqid;
    logic [31:0] dc_wdata;
    logic        dc_flush;
    logic        dc_ready;
    logic        mode_drain;

    lsq_dc_arb #(
        .STARVE_MAX(STARVE_MAX),
        .HIWAT     (HIWAT),
        .LOWAT     (LOWAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_req    (ld_req),
        .ld_op     (ld_op),
        .ld_addr   (ld_addr),
        .ld_lsqid  (ld_lsqid),
        .ld_wdata  (ld_wdata),
        .ld_grant  (ld_grant),
        .st_req    (st_req),
        .st_op     (st_op),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .st_pending(st_pending),
        .st_grant  (st_grant),
        .flush     (flush),
        .dc_req    (dc_req),
        .dc_op     (dc_op),
        .dc_addr   (dc_addr),
        .dc_lsqid  (dc_lsqid),
        .dc_wdata  (dc_wdata),
        .dc_flush  (dc_flush),
        .dc_ready  (dc_ready),
        .mode_drain(mode_drain)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the request currently offered to the dcache, the count
    // of lost arbitrations, and whether stores currently have priority.
    bit          m_req;
    logic [3:0]  m_op;
    logic [31:0] m_addr;
    logic [3:0]  m_lsqid;
    logic [31:0] m_wdata;
    int          m_starve;
    bit          m_drain;
    bit          e_ld;
    bit          e_st;

    task automatic model_reset();
        m_req = 0; m_op = '0; m_addr = '0; m_lsqid = '0; m_wdata = '0;
        m_starve = 0; m_drain = 0;
    endtask

    // Settle inputs, compute expected grants and compare every visible output.
    task automatic settle();
        bit free;
        bit store_first;
        #1;
        free        = !m_req || dc_ready;
        store_first = st_req && (m_drain || m_starve == STARVE_MAX || !ld_req);
        e_st = free && !flush && !rst && store_first;
        e_ld = free && !flush && !rst && !store_first && ld_req;
        check("ld_grant", 32'(ld_grant), 32'(e_ld));
        check("st_grant", 32'(st_grant), 32'(e_st));
        check("dc_req", 32'(dc_req), 32'(m_req));
        check("mode_drain", 32'(mode_drain), 32'(m_drain));
        check("dc_flush", 32'(dc_flush), 32'(flush));
        if (m_req) begin
            check("dc_op", 32'(dc_op), 32'(m_op));
            check("dc_addr", dc_addr, m_addr);
            check("dc_lsqid", 32'(dc_lsqid), 32'(m_lsqid));
            check("dc_wdata", dc_wdata, m_wdata);
        end
    endtask

    // Advance the model by one clock using the current inputs, then move the
    // bench to the next falling edge where new inputs are driven.
    task automatic advance();
        bit free;
        free = !m_req || dc_ready;
        if (rst) begin
            model_reset();
        end else begin
            if (e_st) begin
                m_req = 1; m_op = st_op; m_addr = st_addr; m_lsqid = 0; m_wdata = st_wdata;
            end else if (e_ld) begin
                m_req = 1; m_op = ld_op; m_addr = ld_addr; m_lsqid = ld_lsqid; m_wdata = ld_wdata;
            end else if (m_req && (dc_ready || (flush && !m_op[0]))) begin
                m_req = 0;
            end
            if (e_st)                          m_starve = 0;
            else if (st_req && free && !flush) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            if (int'(st_pending) >= HIWAT)      m_drain = 1;
            else if (int'(st_pending) <= LOWAT) m_drain = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic drive(input bit l, input bit s, input bit rdy, input bit fl);
        ld_req = l; st_req = s; dc_ready = rdy; flush = fl;
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 0, 1, 0);
        ld_op = 4'b0010; ld_addr = 32'h0; ld_lsqid = 4'd0; ld_wdata = 32'h0;
        st_op = 4'b0011; st_addr = 32'h0; st_wdata = 32'h0; st_pending = 5'd0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cycle();                           // grants must stay low during reset
        rst = 1'b0;

        // Reset state of the output stage.
        drive(0, 0, 1, 0);
        settle();
        check("rst_dc_op", 32'(dc_op), 32'h0);
        check("rst_dc_addr", dc_addr, 32'h0);
        check("rst_dc_lsqid", 32'(dc_lsqid), 32'h0);
        check("rst_dc_wdata", dc_wdata, 32'h0);
        advance();

        // First load: grant now, dcache sees it next cycle.
        drive(1, 0, 1, 0);
        ld_lsqid = 4'd5; ld_addr = 32'h0000_1000; ld_wdata = 32'h1111_0000;
        settle();
        check("t1_grant", 32'(ld_grant), 32'h1);
        advance();
        drive(0, 0, 1, 0);
        settle();
        check("t1_dc_req", 32'(dc_req), 32'h1);
        check("t1_dc_lsqid", 32'(dc_lsqid), 32'h5);
        check("t1_dc_addr", dc_addr, 32'h0000_1000);
        advance();

        // Backpressure: a load held for three cycles against pending traffic.
        drive(0, 1, 1, 0); st_addr = 32'h0000_2000; st_wdata = 32'hCAFE_0001;
        cycle();                           // store wins alone, counter cleared
        drive(1, 0, 1, 0); ld_lsqid = 4'd6; ld_addr = 32'h0000_1004;
        cycle();
        drive(1, 1, 0, 0); ld_lsqid = 4'd7; ld_addr = 32'h0000_1008;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_no_grant", 32'(ld_grant | st_grant), 32'h0);
            check("bp_hold_addr", dc_addr, 32'h0000_1004);
            advance();
        end
        drive(1, 1, 1, 0);
        settle();
        check("bp_resume", 32'(ld_grant), 32'h1);
        advance();

        // Starvation: counter is 1 after the resumed load; clear it first.
        drive(0, 1, 1, 0);
        cycle();
        st_pending = 5'd2;
        drive(1, 1, 1, 0);
        for (int i = 0; i < STARVE_MAX; i++) begin
            settle();
            check("starve_ld", 32'(ld_grant), 32'h1);
            advance();
        end
        settle();
        check("starve_st", 32'(st_grant), 32'h1);
        advance();
        settle();
        check("starve_ld_resume", 32'(ld_grant), 32'h1);
        advance();

        // Drain hysteresis.
        drive(0, 1, 1, 0);
        cycle();
        drive(1, 1, 1, 0);
        st_pending = 5'd11;
        cycle();
        st_pending = 5'd12;
        settle();
        check("drain_not_yet", 32'(mode_drain), 32'h0);
        advance();
        settle();
        check("drain_enter", 32'(mode_drain), 32'h1);
        check("drain_st_wins", 32'(st_grant), 32'h1);
        advance();
        st_pending = 5'd5;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("drain_hold", 32'(mode_drain), 32'h1);
            check("drain_hold_st", 32'(st_grant), 32'h1);
            advance();
        end
        st_pending = 5'd4;
        cycle();
        settle();
        check("drain_exit", 32'(mode_drain), 32'h0);
        check("drain_exit_ld", 32'(ld_grant), 32'h1);
        advance();

        // Flush with a held load.
        drive(0, 0, 1, 0);
        cycle();
        drive(1, 0, 0, 0); ld_addr = 32'h0000_3000;
        cycle();
        drive(1, 1, 0, 1);
        settle();
        check("fl_ld_no_grant", 32'(ld_grant | st_grant), 32'h0);
        check("fl_ld_dc_flush", 32'(dc_flush), 32'h1);
        advance();
        drive(0, 0, 0, 0);
        settle();
        check("fl_ld_dropped", 32'(dc_req), 32'h0);
        advance();

        // Flush with a held store.
        drive(0, 1, 0, 0); st_addr = 32'h0000_4000; st_wdata = 32'hBEEF_0004;
        cycle();
        drive(0, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            settle();
            check("fl_st_kept", 32'(dc_req), 32'h1);
            check("fl_st_addr", dc_addr, 32'h0000_4000);
            check("fl_st_data", dc_wdata, 32'hBEEF_0004);
            advance();
        end
        drive(0, 0, 1, 0);
        cycle();
        settle();
        check("fl_st_done", 32'(dc_req), 32'h0);
        advance();

        // Random traffic; st_pending wanders to cross both watermarks.
        for (int i = 0; i < 3000; i++) begin
            ld_req   = ($urandom_range(0, 99) < 70);
            st_req   = ($urandom_range(0, 99) < 60);
            dc_ready = ($urandom_range(0, 99) < 65);
            flush    = ($urandom_range(0, 99) < 8);
            ld_op    = {3'($urandom), 1'b0};
            st_op    = {3'($urandom), 1'b1};
            ld_addr  = $urandom;
            st_addr  = $urandom;
            ld_lsqid = 4'($urandom);
            ld_wdata = $urandom;
            st_wdata = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (st_pending < 5'd16) st_pending = st_pending + 5'd1;
            end else begin
                if (st_pending > 5'd0) st_pending = st_pending - 5'd1;
            end
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            else                             rst = 1'b0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
